alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Upstream/downstream companion of the ALU. Accepts one instruction word, decodes it,
//  reads operands from an internal register file and drives opcode/input1/input2/alu_enable.
//  Captures alu_out on the following cycle and writes it back to the destination register.
//  Non-pipelined: one instruction in flight, 3-cycle issue-to-writeback loop.
// PARAMETERS
//  WORD_SIZE   16  datapath and instruction width; must match the ALU
//  OPCODE_SIZE 4   opcode field width, instr[WORD_SIZE-1 -: OPCODE_SIZE]
//  NUM_REGS    8   register count; REG_BITS = $clog2(NUM_REGS) = 3
// PORTS
//  clock        in   1          single clock, all state updates on posedge
//  reset        in   1          synchronous, active-high
//  instr_valid  in   1          instruction word present
//  instr        in   WORD_SIZE  {opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3] | imm6[5:0]}
//  instr_ready  out  1          stage can accept; high only in IDLE
//  opcode       out  OPCODE_SIZE  to ALU
//  input1       out  WORD_SIZE  to ALU, R[rs1]
//  input2       out  WORD_SIZE  to ALU, R[rs2] or the extended immediate
//  alu_enable   out  1          to ALU, one-cycle pulse
//  alu_out      in   WORD_SIZE  from ALU, valid the cycle after alu_enable
//  wb_valid     out  1          writeback pulse
//  wb_addr      out  REG_BITS   destination register
//  wb_data      out  WORD_SIZE  value written
//  illegal_op   out  1          pulse when a non-ALU opcode is dropped
//  dbg_addr     in   REG_BITS   combinational debug read address
//  dbg_data     out  WORD_SIZE  R[dbg_addr]; R0 reads 0
//  issue_count  out  16         ops issued (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; R1..R7=0; instr_ready=1; alu_enable, wb_valid, illegal_op=0;
//   opcode, input1, input2, wb_addr, wb_data=0; issue_count=0.
//  FSM IDLE -> ISSUE -> WB -> IDLE.
//   IDLE: instr_valid&instr_ready latches the decoded fields. For an ALU opcode
//    (NOT, AND, ANDI, OR, XOR, ADD, ADDI, SUB, COMP, LT, EQ) the FSM goes to ISSUE.
//    For any other opcode it pulses illegal_op the next cycle and stays in IDLE.
//   ISSUE: alu_enable=1 for exactly this cycle, with opcode/input1/input2 registered and stable.
//   WB: sample alu_out; if rd!=0 write R[rd]. wb_valid=1 with wb_addr/wb_data. Return to IDLE.
//  Latency: accept in cycle N -> alu_enable in N+1 -> wb_valid and register update in N+2
//   -> instr_ready high in N+3.
//  Operands: register reads happen at accept time, in the IDLE cycle.
//   ADDI: input2 = sign-extended imm6. ANDI: input2 = zero-extended imm6.
//   NOT: input2 = 0. Everything else: input2 = R[rs2].
//  R0 is hardwired to 0. A write with rd=0 still pulses wb_valid but leaves state unchanged.
//  instr_valid while busy: ignored. The producer must hold the word until instr_ready is seen.
//  Reset mid-ISSUE or mid-WB: the operation is aborted with no writeback, and the reset values apply.
//  Back-to-back dependency (rs1 = previous rd) always sees the written value, since WB
//   precedes the next accept.
// CONFIGURATION
//  `ALU_ISSUE_COUNT_EN defined: issue_count increments on every alu_enable pulse and
//   saturates at 16'hFFFF. Cleared by reset.
//  Not defined: issue_count is tied to 16'h0000 and no counter logic is built.
// STRUCTURE
//  Opcode defines (`NOT, `ADD, ...), WORD_SIZE and OPCODE_SIZE come from the shared
//   parameters.vh. The state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WB=2'd2)
//   are added there too.
//  One sub-module: issue_register_file. It has 2 combinational read ports plus the debug
//   port, 1 synchronous write port, and R0=0.
// TESTING
//  1. Reset, then ADDI R1,R0,#5 -> alu_enable at N+1 with input2=16'h0005;
//     wb_valid at N+2 with R1=5.
//  2. ADDI R2,R0,#-1 (imm6=6'h3F) -> input2=16'hFFFF, R2=16'hFFFF.
//     Then ADD R3,R1,R2 -> R3=16'h0004.
//  3. SUB R4,R1,R1 -> R4=0. LT R5,R1,R2 (5<65535 unsigned) -> R5=1.
//     EQ R6,R1,R1 -> R6=1.
//  4. ADD R0,R1,R1 -> wb_valid=1, wb_data=10, dbg read R0 = 0.
//     Opcode not in the ALU set -> illegal_op pulse, no alu_enable.
//  5. Hold instr_valid high during ISSUE/WB -> exactly one acceptance.
//     Reset asserted in ISSUE -> no wb_valid, all registers read 0.
//  6. With `ALU_ISSUE_COUNT_EN: 3 ops -> issue_count=3; the illegal op is not counted.
//     Without the macro -> issue_count stays 0.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants, opcode map, FSM encoding and decode helpers for the ALU issue stage.
package alu_issue_stage_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned OPCODE_SIZE = 4;
    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned REG_BITS    = $clog2(NUM_REGS);
    localparam int unsigned IMM_BITS    = 6;

    localparam logic [OPCODE_SIZE-1:0] OpNot  = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OpAnd  = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] OpAndi = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] OpOr   = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] OpXor  = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] OpAdd  = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] OpAddi = 4'd6;
    localparam logic [OPCODE_SIZE-1:0] OpSub  = 4'd7;
    localparam logic [OPCODE_SIZE-1:0] OpComp = 4'd8;
    localparam logic [OPCODE_SIZE-1:0] OpLt   = 4'd9;
    localparam logic [OPCODE_SIZE-1:0] OpEq   = 4'd10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWb    = 2'd2
    } state_e;

    // ALU opcodes occupy the contiguous range 0..10; 11..15 are dropped as illegal.
    function automatic logic is_alu_op(input logic [OPCODE_SIZE-1:0] op);
        return op <= OpEq;
    endfunction

    function automatic logic [WORD_SIZE-1:0] operand2(input logic [OPCODE_SIZE-1:0] op,
                                                      input logic [IMM_BITS-1:0]    imm6,
                                                      input logic [WORD_SIZE-1:0]   rs2_data);
        case (op)
            OpAddi:  return {{(WORD_SIZE-IMM_BITS){imm6[IMM_BITS-1]}}, imm6};
            OpAndi:  return {{(WORD_SIZE-IMM_BITS){1'b0}}, imm6};
            OpNot:   return '0;
            default: return rs2_data;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, ALU drive/return, writeback, debug and counter signals of the issue stage.
interface alu_issue_stage_if
    import alu_issue_stage_pkg::*;
();
    logic                   instr_valid;
    logic [WORD_SIZE-1:0]   instr;
    logic                   instr_ready;
    logic [OPCODE_SIZE-1:0] opcode;
    logic [WORD_SIZE-1:0]   input1;
    logic [WORD_SIZE-1:0]   input2;
    logic                   alu_enable;
    logic [WORD_SIZE-1:0]   alu_out;
    logic                   wb_valid;
    logic [REG_BITS-1:0]    wb_addr;
    logic [WORD_SIZE-1:0]   wb_data;
    logic                   illegal_op;
    logic [REG_BITS-1:0]    dbg_addr;
    logic [WORD_SIZE-1:0]   dbg_data;
    logic [15:0]            issue_count;

    modport slave (
        input  instr_valid, instr, alu_out, dbg_addr,
        output instr_ready, opcode, input1, input2, alu_enable,
               wb_valid, wb_addr, wb_data, illegal_op, dbg_data, issue_count
    );

    modport master (
        output instr_valid, instr, alu_out, dbg_addr,
        input  instr_ready, opcode, input1, input2, alu_enable,
               wb_valid, wb_addr, wb_data, illegal_op, dbg_data, issue_count
    );
endinterface

// File: rtl/issue_register_file.sv
// Register file: two combinational read ports plus a debug port, one synchronous write, R0 = 0.
module issue_register_file #(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned NUM_REGS  = 8,
    localparam int unsigned ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr_a,
    output logic [WIDTH-1:0]     o_rdata_a,
    input  logic [ADDR_BITS-1:0] i_raddr_b,
    output logic [WIDTH-1:0]     o_rdata_b,
    input  logic [ADDR_BITS-1:0] i_dbg_addr,
    output logic [WIDTH-1:0]     o_dbg_data
);
    logic [WIDTH-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_regs <= '{default: '0};
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_regs[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
endmodule

// File: rtl/alu_issue_stage.sv
// Non-pipelined ALU issue stage: accept, issue to ALU, write back (IDLE -> ISSUE -> WB).
// Define ALU_ISSUE_COUNT_EN to build the saturating issue counter; otherwise issue_count is 0.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    alu_issue_stage_if.slave bus
);
    state_e                 r_state;
    logic [OPCODE_SIZE-1:0] r_opcode;
    logic [WORD_SIZE-1:0]   r_input1;
    logic [WORD_SIZE-1:0]   r_input2;
    logic [REG_BITS-1:0]    r_rd;
    logic                   r_alu_enable;
    logic                   r_illegal_op;

    logic [OPCODE_SIZE-1:0] w_op;
    logic [REG_BITS-1:0]    w_rd;
    logic [REG_BITS-1:0]    w_rs1;
    logic [REG_BITS-1:0]    w_rs2;
    logic [IMM_BITS-1:0]    w_imm6;
    logic [WORD_SIZE-1:0]   w_rs1_data;
    logic [WORD_SIZE-1:0]   w_rs2_data;
    logic                   w_accept;
    logic                   w_in_wb;

    assign w_op     = bus.instr[WORD_SIZE-1 -: OPCODE_SIZE];
    assign w_rd     = bus.instr[11:9];
    assign w_rs1    = bus.instr[8:6];
    assign w_rs2    = bus.instr[5:3];
    assign w_imm6   = bus.instr[5:0];
    assign w_accept = bus.instr_valid && (r_state == StIdle);
    assign w_in_wb  = (r_state == StWb);

    // Writes land at the end of WB, so the next accept already reads the new value.
    issue_register_file #(
        .WIDTH    (WORD_SIZE),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clock      (clock),
        .reset      (reset),
        .i_we       (w_in_wb),
        .i_waddr    (r_rd),
        .i_wdata    (bus.alu_out),
        .i_raddr_a  (w_rs1),
        .o_rdata_a  (w_rs1_data),
        .i_raddr_b  (w_rs2),
        .o_rdata_b  (w_rs2_data),
        .i_dbg_addr (bus.dbg_addr),
        .o_dbg_data (bus.dbg_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_opcode     <= '0;
            r_input1     <= '0;
            r_input2     <= '0;
            r_rd         <= '0;
            r_alu_enable <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_alu_enable <= 1'b0;
            r_illegal_op <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (is_alu_op(w_op)) begin
                            r_state      <= StIssue;
                            r_opcode     <= w_op;
                            r_rd         <= w_rd;
                            r_input1     <= w_rs1_data;
                            r_input2     <= operand2(w_op, w_imm6, w_rs2_data);
                            r_alu_enable <= 1'b1;
                        end else begin
                            r_illegal_op <= 1'b1;
                        end
                    end
                end
                StIssue: r_state <= StWb;
                StWb:    r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == StIdle);
    assign bus.opcode      = r_opcode;
    assign bus.input1      = r_input1;
    assign bus.input2      = r_input2;
    assign bus.alu_enable  = r_alu_enable;
    assign bus.illegal_op  = r_illegal_op;
    assign bus.wb_valid    = w_in_wb;
    assign bus.wb_addr     = w_in_wb ? r_rd : '0;
    assign bus.wb_data     = w_in_wb ? bus.alu_out : '0;

`ifdef ALU_ISSUE_COUNT_EN
    logic [15:0] r_issue_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_count <= '0;
        end else if (r_alu_enable && (r_issue_count != 16'hFFFF)) begin
            r_issue_count <= r_issue_count + 16'd1;
        end
    end

    assign bus.issue_count = r_issue_count;
`else
    assign bus.issue_count = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a registered ALU responder and immediate assertions.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            OpNot:         return ~a;
            OpAnd, OpAndi: return a & b;
            OpOr:          return a | b;
            OpXor:         return a ^ b;
            OpAdd, OpAddi: return a + b;
            OpSub:         return a - b;
            OpComp:        return {15'd0, a >= b};
            OpLt:          return {15'd0, a < b};
            OpEq:          return {15'd0, a == b};
            default:       return 16'h0000;
        endcase
    endfunction

    // ALU model: result registered on the alu_enable edge, valid the following cycle.
    always @(posedge clock) begin
        if (reset) bus.alu_out <= 16'h0000;
        else if (bus.alu_enable) bus.alu_out <= alu_f(bus.opcode, bus.input1, bus.input2);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] itype(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [5:0] imm6);
        return {op, rd, rs1, imm6};
    endfunction

    function automatic logic [15:0] rtype(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] w, input logic [15:0] e_in1,
                          input logic [15:0] e_in2, input logic [15:0] e_data);
        logic [3:0] e_op;
        logic [2:0] e_rd;
        e_op = w[15:12];
        e_rd = w[11:9];
        check({tag, ".ready"}, bus.instr_ready, 1'b1);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        step();
        bus.instr_valid = 1'b0;
        check({tag, ".alu_en"}, bus.alu_enable, 1'b1);
        check({tag, ".opcode"}, bus.opcode, e_op);
        check({tag, ".in1"}, bus.input1, e_in1);
        check({tag, ".in2"}, bus.input2, e_in2);
        check({tag, ".busy"}, bus.instr_ready, 1'b0);
        step();
        check({tag, ".alu_en_off"}, bus.alu_enable, 1'b0);
        check({tag, ".wb_valid"}, bus.wb_valid, 1'b1);
        check({tag, ".wb_addr"}, bus.wb_addr, e_rd);
        check({tag, ".wb_data"}, bus.wb_data, e_data);
        step();
        check({tag, ".ready_back"}, bus.instr_ready, 1'b1);
        check({tag, ".wb_off"}, bus.wb_valid, 1'b0);
        bus.dbg_addr = e_rd;
        #1;
        check({tag, ".reg"}, bus.dbg_data, (e_rd == 3'd0) ? 16'h0000 : e_data);
    endtask

    initial begin
        int pulses;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.dbg_addr    = 3'd0;
        step();
        step();
        check("rst.ready", bus.instr_ready, 1'b1);
        check("rst.alu_en", bus.alu_enable, 1'b0);
        check("rst.wb_valid", bus.wb_valid, 1'b0);
        check("rst.illegal", bus.illegal_op, 1'b0);
        check("rst.opcode", bus.opcode, 4'h0);
        check("rst.in1", bus.input1, 16'h0000);
        check("rst.in2", bus.input2, 16'h0000);
        check("rst.wb_addr", bus.wb_addr, 3'd0);
        check("rst.wb_data", bus.wb_data, 16'h0000);
        check("rst.count", bus.issue_count, 16'h0000);
        reset = 1'b0;
        step();

        run_op("addi_r1", itype(OpAddi, 3'd1, 3'd0, 6'd5), 16'h0000, 16'h0005, 16'h0005);
        run_op("addi_r2", itype(OpAddi, 3'd2, 3'd0, 6'h3F), 16'h0000, 16'hFFFF, 16'hFFFF);
        run_op("add_r3", rtype(OpAdd, 3'd3, 3'd1, 3'd2), 16'h0005, 16'hFFFF, 16'h0004);
        run_op("sub_r4", rtype(OpSub, 3'd4, 3'd1, 3'd1), 16'h0005, 16'h0005, 16'h0000);
        run_op("lt_r5", rtype(OpLt, 3'd5, 3'd1, 3'd2), 16'h0005, 16'hFFFF, 16'h0001);
        run_op("eq_r6", rtype(OpEq, 3'd6, 3'd1, 3'd1), 16'h0005, 16'h0005, 16'h0001);
        run_op("andi_r7", itype(OpAndi, 3'd7, 3'd2, 6'h3F), 16'hFFFF, 16'h003F, 16'h003F);
        run_op("not_r7", itype(OpNot, 3'd7, 3'd1, 6'h3F), 16'h0005, 16'h0000, 16'hFFFA);
        run_op("add_r0", rtype(OpAdd, 3'd0, 3'd1, 3'd1), 16'h0005, 16'h0005, 16'h000A);

        // Opcode 15 is outside the ALU set.
        bus.instr_valid = 1'b1;
        bus.instr       = itype(4'hF, 3'd1, 3'd1, 6'd0);
        step();
        bus.instr_valid = 1'b0;
        check("ill.pulse", bus.illegal_op, 1'b1);
        check("ill.no_alu", bus.alu_enable, 1'b0);
        check("ill.ready", bus.instr_ready, 1'b1);
        step();
        check("ill.pulse_end", bus.illegal_op, 1'b0);
        check("ill.no_alu2", bus.alu_enable, 1'b0);
        bus.dbg_addr = 3'd1;
        #1;
        check("ill.r1_kept", bus.dbg_data, 16'h0005);

        // Valid held through ISSUE/WB must be accepted once.
        pulses          = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = rtype(OpAdd, 3'd7, 3'd1, 3'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.alu_enable) pulses++;
        end
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.alu_enable) pulses++;
        end
        check("hold.pulses", pulses, 1);
        bus.dbg_addr = 3'd7;
        #1;
        check("hold.r7", bus.dbg_data, 16'h000A);
`ifdef ALU_ISSUE_COUNT_EN
        check("cnt.before_rst", bus.issue_count, 16'd10);
`else
        check("cnt.before_rst", bus.issue_count, 16'd0);
`endif

        // Reset during ISSUE aborts the writeback.
        bus.instr_valid = 1'b1;
        bus.instr       = rtype(OpAdd, 3'd1, 3'd2, 3'd2);
        step();
        bus.instr_valid = 1'b0;
        check("abort.in_issue", bus.alu_enable, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.no_wb", bus.wb_valid, 1'b0);
        check("abort.ready", bus.instr_ready, 1'b1);
        step();
        check("abort.no_wb2", bus.wb_valid, 1'b0);
        for (int r = 1; r < 8; r++) begin
            bus.dbg_addr = 3'(r);
            #1;
            check($sformatf("abort.r%0d", r), bus.dbg_data, 16'h0000);
        end
        check("cnt.after_rst", bus.issue_count, 16'd0);

        run_op("addi_a", itype(OpAddi, 3'd1, 3'd0, 6'h15), 16'h0000, 16'h0015, 16'h0015);
        run_op("addi_b", itype(OpAddi, 3'd2, 3'd0, 6'h0C), 16'h0000, 16'h000C, 16'h000C);
        run_op("xor_c", rtype(OpXor, 3'd3, 3'd1, 3'd2), 16'h0015, 16'h000C, 16'h0019);
`ifdef ALU_ISSUE_COUNT_EN
        check("cnt.three", bus.issue_count, 16'd3);
`else
        check("cnt.three", bus.issue_count, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
